// File: rtl/ws2811_frame_splitter.sv
// Splits a recovered WS2811 frame: leading bits stay local as a payload,
// the remainder is re-strobed towards the downstream encoder.
module ws2811_frame_splitter #(
   parameter int CAPTURE_BITS     = 32,
   parameter int CLK_PULSE_CYCLES = 4,
   parameter int CNT_W            = 16
) (
   input  logic             masterClk,
   input  logic             nReset,
   input  logic             dataIn,
   input  logic             dataClkIn,
   input  logic             activeIn,
   output logic             dataOut,
   output logic             dataClkOut,
   output logic [31:0]      frameData,
   output logic             frameValid,
   output logic             frameShort,
   output logic [CNT_W-1:0] bitCount
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CAPTURE = 2'd1;
   localparam logic [1:0] S_FORWARD = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(CAPTURE_BITS);
   localparam logic [3:0]       PULSE_M1 = 4'(CLK_PULSE_CYCLES - 1);

   logic             clk_q;
   logic             clk_d;
   logic             act_q;
   logic             act_d;
   logic             bit_ev;
   logic             act_rise;
   logic             act_fall;
   logic             fwd_ev;
   logic [1:0]       state;
   logic [31:0]      shadow;
   logic [3:0]       pulse_rem;
   logic [CNT_W-1:0] cnt_inc;

   assign bit_ev   = clk_q & ~clk_d;
   assign act_rise = act_q & ~act_d;
   assign act_fall = ~act_q & act_d;
   assign fwd_ev   = bit_ev && (state == S_FORWARD);
   assign cnt_inc  = (bitCount == '1) ? bitCount : bitCount + CNT_ONE;

   // activity history resets high so a frame already running at
   // reset release is never mistaken for a fresh frame start
   always_ff @(posedge masterClk or negedge nReset) begin
      if (!nReset) begin
         clk_q <= 1'b0;
         clk_d <= 1'b0;
         act_q <= 1'b1;
         act_d <= 1'b1;
      end else begin
         clk_q <= dataClkIn;
         clk_d <= clk_q;
         act_q <= activeIn;
         act_d <= act_q;
      end
   end

   // a new forwarded bit restarts the strobe, so close bits merge
   always_ff @(posedge masterClk or negedge nReset) begin
      if (!nReset) begin
         dataOut    <= 1'b0;
         dataClkOut <= 1'b0;
         pulse_rem  <= 4'd0;
      end else if (fwd_ev) begin
         dataOut    <= dataIn;
         dataClkOut <= 1'b1;
         pulse_rem  <= PULSE_M1;
      end else if (pulse_rem != 4'd0) begin
         pulse_rem  <= pulse_rem - 4'd1;
      end else begin
         dataClkOut <= 1'b0;
      end
   end

   always_ff @(posedge masterClk or negedge nReset) begin
      if (!nReset) begin
         state      <= S_IDLE;
         shadow     <= 32'd0;
         bitCount   <= '0;
         frameData  <= 32'd0;
         frameValid <= 1'b0;
         frameShort <= 1'b0;
      end else begin
         frameValid <= 1'b0;
         frameShort <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (act_rise) begin
                  state    <= S_CAPTURE;
                  bitCount <= '0;
                  shadow   <= 32'd0;
               end
            end
            S_CAPTURE: begin
               if (bit_ev) begin
                  shadow   <= {shadow[30:0], dataIn};
                  bitCount <= cnt_inc;
               end
               if (act_fall) begin
                  state <= S_DONE;
               end else if (bit_ev && cnt_inc == CNT_CAP) begin
                  state <= S_FORWARD;
               end
            end
            S_FORWARD: begin
               if (bit_ev) begin
                  bitCount <= cnt_inc;
               end
               if (act_fall) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               if (bitCount >= CNT_CAP) begin
                  frameData  <= shadow;
                  frameValid <= 1'b1;
               end else begin
                  frameShort <= 1'b1;
               end
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
